// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule: expands a cipher key forward to round key 10,
// then streams round keys 10 down to 0 over a valid/ready handshake.
module inv_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         done
);

  localparam int unsigned KW = 128;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LAST_ROUND = CW'(10);
  localparam logic [CW-1:0] FWD_END    = CW'(11);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] key_q, key_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {SBOX[r[31:24]], SBOX[r[23:16]], SBOX[r[15:8]], SBOX[r[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input logic [CW-1:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [KW-1:0] fwd_step(input logic [KW-1:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo one forward step: recover w3..w1 first, then w0 from the recovered w3.
  function automatic logic [KW-1:0] inv_step(input logic [KW-1:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0]  ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_rot(p3) ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Counter runs 1..10 through the forward steps; the extra count 11 gives
  // the fixed 11-cycle start-to-valid latency before emission begins.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b1;
    valid_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          key_d   = key;
          cnt_d   = CW'(1);
          state_d = FWD;
          busy_d  = 1'b1;
        end
      end
      FWD: begin
        if (cnt_q == FWD_END) begin
          state_d = EMIT;
          cnt_d   = LAST_ROUND;
          valid_d = 1'b1;
        end else begin
          key_d = fwd_step(key_q, rcon(cnt_q));
          cnt_d = cnt_q + CW'(1);
        end
      end
      EMIT: begin
        valid_d = 1'b1;
        if (valid_q && rk_ready) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            key_d = inv_step(key_q, rcon(cnt_q));
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = busy_q;
  assign rk_valid = valid_q;
  assign done     = done_q;
  assign rk       = key_q;
  assign rk_idx   = cnt_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule: table of runs against known AES-128
// round keys, plus reset-abort and start-collision sequences.
module tb_inv_key_schedule;

  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK10_ZERO = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  typedef struct {
    logic [127:0] k;
    bit           rand_ready;
    bit           full;
    bit           poke;
    bit           end_start;
    logic [127:0] e10;
    logic [127:0] e0;
  } run_t;

  run_t         runs [6];
  logic [127:0] fips_rk [11];

  inv_key_schedule dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key      (key),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk       (rk),
    .rk_idx   (rk_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Start a run at a negedge, check latency, then collect all 11 keys.
  task automatic run_key(input run_t r);
    int           lat;
    int           ecyc;
    int           exp_idx;
    bit           rdy;
    bit           held;
    logic [127:0] hold_rk;
    logic [3:0]   hold_idx;
    logic [127:0] want;
    key = r.k;
    start = 1'b1;
    rk_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    key = ~r.k;
    chk1("busy after start", busy, 1'b1);
    chk1("done low after start", done, 1'b0);
    lat = 0;
    while (!rk_valid && lat < 30) begin
      start = r.poke && (lat == 3);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("start-to-valid latency", 128'(lat), 128'd11);
    exp_idx = 10;
    ecyc = 0;
    held = 1'b0;
    hold_rk = '0;
    hold_idx = '0;
    while (exp_idx >= 0 && ecyc < 200) begin
      if (!rk_valid) begin
        chk1("valid during emit", rk_valid, 1'b1);
        exp_idx = -1;
      end else begin
        if (held) begin
          chk("hold rk", rk, hold_rk);
          chk("hold rk_idx", 128'(rk_idx), 128'(hold_idx));
        end
        rdy = r.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        start = (r.poke && ecyc == 2) || (r.end_start && rdy && exp_idx == 0);
        rk_ready = rdy;
        if (rdy) begin
          chk("rk_idx order", 128'(rk_idx), 128'(exp_idx));
          want = r.full ? fips_rk[exp_idx] : ((exp_idx == 10) ? r.e10 : r.e0);
          if (r.full || exp_idx == 10 || exp_idx == 0)
            chk($sformatf("rk idx%0d", exp_idx), rk, want);
          exp_idx--;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hold_rk = rk;
          hold_idx = rk_idx;
        end
        @(negedge clk);
        ecyc++;
      end
    end
    start = 1'b0;
    rk_ready = 1'b0;
    chk1("done pulse", done, 1'b1);
    chk1("valid low after last", rk_valid, 1'b0);
    chk1("busy low after last", busy, 1'b0);
    chk("rk keeps round 0", rk, r.full ? fips_rk[0] : r.e0);
  endtask

  initial begin
    fips_rk[0]  = KEY_FIPS;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = RK10_FIPS;

    runs[0] = '{KEY_FIPS, 1'b0, 1'b1, 1'b0, 1'b0, RK10_FIPS, KEY_FIPS};
    runs[1] = '{KEY_FIPS, 1'b1, 1'b1, 1'b0, 1'b0, RK10_FIPS, KEY_FIPS};
    runs[2] = '{128'h0,   1'b0, 1'b0, 1'b0, 1'b0, RK10_ZERO, 128'h0};
    runs[3] = '{KEY_FIPS, 1'b0, 1'b1, 1'b1, 1'b0, RK10_FIPS, KEY_FIPS};
    runs[4] = '{KEY_FIPS, 1'b1, 1'b1, 1'b0, 1'b1, RK10_FIPS, KEY_FIPS};
    runs[5] = '{128'h0,   1'b0, 1'b0, 1'b0, 1'b0, RK10_ZERO, 128'h0};

    rst = 1'b1;
    start = 1'b0;
    key = '0;
    rk_ready = 1'b0;
    @(negedge clk);
    chk1("reset busy", busy, 1'b0);
    chk1("reset rk_valid", rk_valid, 1'b0);
    chk1("reset done", done, 1'b0);
    chk("reset rk", rk, 128'h0);
    chk("reset rk_idx", 128'(rk_idx), 128'h0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_key(runs[i]);

    // Abort mid-emission, then restart on the first edge after reset.
    key = KEY_FIPS;
    start = 1'b1;
    rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key = '0;
    cyc = 0;
    while (!(rk_valid && rk_idx == 4'd5) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached idx 5", 128'(rk_idx), 128'd5);
    rst = 1'b1;
    #1;
    chk1("abort busy", busy, 1'b0);
    chk1("abort rk_valid", rk_valid, 1'b0);
    chk1("abort done", done, 1'b0);
    chk("abort rk", rk, 128'h0);
    chk("abort rk_idx", 128'(rk_idx), 128'h0);
    @(negedge clk);
    chk1("valid held low in reset", rk_valid, 1'b0);
    chk1("done held low in reset", done, 1'b0);
    rst = 1'b0;
    rk_ready = 1'b0;
    run_key(runs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
